// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter / burst sequencer.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first).
package ram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } ram_arb_state_e;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_LEN_W  = 4;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way requester picker: round-robin by default, fixed priority to requester 0
// when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] win_o,
    output logic       prio_nxt_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_prio_s;
    assign unused_prio_s = prio_i;

    // Requester 0 always wins; the pointer is constant so it folds away.
    always_comb begin
        prio_nxt_o = 1'b0;
        if (req_i[0]) begin
            win_o = 2'b01;
        end else if (req_i[1]) begin
            win_o = 2'b10;
        end else begin
            win_o = 2'b00;
        end
    end
`else
    // The pointer always moves to whichever requester was not granted.
    always_comb begin
        win_o      = 2'b00;
        prio_nxt_o = prio_i;
        case (req_i)
            2'b01: begin
                win_o      = 2'b01;
                prio_nxt_o = 1'b1;
            end
            2'b10: begin
                win_o      = 2'b10;
                prio_nxt_o = 1'b0;
            end
            2'b11: begin
                win_o      = idx_to_onehot(prio_i);
                prio_nxt_o = ~prio_i;
            end
            default: begin
                win_o      = 2'b00;
                prio_nxt_o = prio_i;
            end
        endcase
    end
`endif

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-port arbiter and burst sequencer in front of a single-port 256x32 RAM.
// Build option: RAM_ARB_FIXED_PRIO_EN (handled in ram_arb_rr) selects fixed priority.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = RAM_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              beat0,
    output logic              beat1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_dout
);

    ram_arb_state_e    state_q;
    logic              prio_q;
    logic              prio_d;
    logic [1:0]        win;
    logic              we_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ram_rw_q;
    logic              beat0_q;
    logic              beat1_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    ram_arb_rr u_rr (
        .req_i      ({req1, req0}),
        .prio_i     (prio_q),
        .win_o      (win),
        .prio_nxt_o (prio_d)
    );

    // Burst parameters of the requester that wins in IDLE.
    always_comb begin
        if (win[1]) begin
            sel_we   = we1;
            sel_addr = addr1;
            sel_len  = len1;
        end else begin
            sel_we   = we0;
            sel_addr = addr0;
            sel_len  = len0;
        end
    end

    // FSM, beat counter, address incrementer and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= {LEN_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            ram_rw_q  <= 1'b0;
            beat0_q   <= 1'b0;
            beat1_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            // we_q still describes the beat being retired at this edge.
            rvalid0_q <= beat0_q & ~we_q;
            rvalid1_q <= beat1_q & ~we_q;
            case (state_q)
                IDLE: begin
                    if (win != 2'b00) begin
                        state_q  <= BURST;
                        prio_q   <= prio_d;
                        we_q     <= sel_we;
                        cnt_q    <= sel_len;
                        addr_q   <= sel_addr;
                        ram_rw_q <= sel_we;
                        beat0_q  <= win[0];
                        beat1_q  <= win[1];
                        gnt0_q   <= win[0];
                        gnt1_q   <= win[1];
                    end else begin
                        ram_rw_q <= 1'b0;
                        beat0_q  <= 1'b0;
                        beat1_q  <= 1'b0;
                    end
                end
                BURST: begin
                    if (cnt_q == {LEN_W{1'b0}}) begin
                        state_q  <= IDLE;
                        ram_rw_q <= 1'b0;
                        beat0_q  <= 1'b0;
                        beat1_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - LEN_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ram_rw_q <= 1'b0;
                    beat0_q  <= 1'b0;
                    beat1_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_din  = beat1_q ? wdata1 : (beat0_q ? wdata0 : {DATA_W{1'b0}});
    assign ram_addr = addr_q;
    assign ram_rw   = ram_rw_q;
    assign beat0    = beat0_q;
    assign beat1    = beat1_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = ram_dout;
    assign rdata1   = ram_dout;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Scoreboard bench for ram_arbiter_2p with a behavioural 256x32 RAM attached.
module tb_ram_arbiter_2p;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [3:0]  len0, len1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, beat0, beat1, rvalid0, rvalid1, busy, ram_rw;
    logic [31:0] rdata0, rdata1, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    ram_arbiter_2p dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .beat0(beat0), .beat1(beat1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_rw(ram_rw),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write on RW=1, read data one cycle after the address.
    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int p; bit we; logic [7:0] a; logic [31:0] d; bit g; int gap;} beat_t;
    typedef struct {int p; logic [31:0] d;} rd_t;
    beat_t bq[$];
    rd_t   rq[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;

    function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_burst(input int p, input bit we, input logic [7:0] a,
                                       input logic [3:0] l, input logic [31:0] base, input int gap);
        beat_t b;
        rd_t   r;
        for (int k = 0; k <= int'(l); k++) begin
            b.p = p; b.we = we; b.a = a + 8'(k); b.d = base + 32'(k);
            b.g = (k == 0); b.gap = (k == 0) ? gap : 1;
            bq.push_back(b);
            if (!we) begin
                r.p = p; r.d = base + 32'(k);
                rq.push_back(r);
            end
        end
    endfunction

    // Monitor: compares every beat and every read return against the queues.
    beat_t mb;
    rd_t   mr;
    int    last_beat = -100;
    always @(negedge clk) begin
        if (mon_en) begin
            if (beat0 || beat1) begin
                if (bq.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {30'b0, beat1, beat0}, 32'h0);
                end else begin
                    mb = bq.pop_front();
                    chk({beat1, beat0} == ((mb.p != 0) ? 2'b10 : 2'b01), "beat_owner",
                        {30'b0, beat1, beat0}, (mb.p != 0) ? 32'h2 : 32'h1);
                    chk(ram_addr == mb.a, "ram_addr", {24'b0, ram_addr}, {24'b0, mb.a});
                    chk(ram_rw == mb.we, "ram_rw", {31'b0, ram_rw}, {31'b0, mb.we});
                    if (mb.we) chk(ram_din == mb.d, "ram_din", ram_din, mb.d);
                    chk({gnt1, gnt0} == (mb.g ? ((mb.p != 0) ? 2'b10 : 2'b01) : 2'b00), "gnt",
                        {30'b0, gnt1, gnt0}, mb.g ? ((mb.p != 0) ? 32'h2 : 32'h1) : 32'h0);
                    chk(busy == 1'b1, "busy_in_burst", {31'b0, busy}, 32'h1);
                    if (mb.gap != 0)
                        chk(cyc - last_beat == mb.gap, "beat_gap", 32'(cyc - last_beat), 32'(mb.gap));
                end
                last_beat = cyc;
            end else begin
                chk({gnt1, gnt0, ram_rw, busy, ram_din == 32'h0} == 5'b00001, "idle_outputs",
                    {27'b0, gnt1, gnt0, ram_rw, busy, ram_din == 32'h0}, 32'h1);
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    chk(1'b0, "unexpected_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
                end else begin
                    mr = rq.pop_front();
                    chk({rvalid1, rvalid0} == ((mr.p != 0) ? 2'b10 : 2'b01), "rvalid_owner",
                        {30'b0, rvalid1, rvalid0}, (mr.p != 0) ? 32'h2 : 32'h1);
                    chk(((mr.p != 0) ? rdata1 : rdata0) == mr.d, "rdata",
                        (mr.p != 0) ? rdata1 : rdata0, mr.d);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int p, input int lat);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            got = (p == 0) ? gnt0 : gnt1;
        end
        if (!got) chk(1'b0, "gnt_timeout", 32'(n), 32'(lat));
        else if (lat > 0) chk(n == lat, "gnt_latency", 32'(n), 32'(lat));
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    // Issue one burst, wait for its grant, then feed write data beat by beat.
    task automatic drive(input int p, input bit we, input logic [7:0] a, input logic [3:0] l,
                         input logic [31:0] wb, input int lat);
        if (p == 0) begin we0 = we; addr0 = a; len0 = l; req0 = 1'b1; end
        else begin we1 = we; addr1 = a; len1 = l; req1 = 1'b1; end
        wait_gnt(p, lat);
        for (int k = 0; k <= int'(l); k++) begin
            if (p == 0) wdata0 = wb + 32'(k);
            else wdata1 = wb + 32'(k);
            if (k < int'(l)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h0; addr1 = 8'h0; len0 = 4'h0; len1 = 4'h0;
        wdata0 = 32'h0; wdata1 = 32'h0;
        idle(3);
        chk({gnt1, gnt0, beat1, beat0, rvalid1, rvalid0, busy, ram_rw} == 8'h00, "reset_ctrl",
            {24'b0, gnt1, gnt0, beat1, beat0, rvalid1, rvalid0, busy, ram_rw}, 32'h0);
        chk(ram_addr == 8'h00, "reset_addr", {24'b0, ram_addr}, 32'h0);
        chk(ram_din == 32'h0, "reset_din", ram_din, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Write burst, then read it back on the other port.
        push_burst(0, 1'b1, 8'h10, 4'd3, 32'hA0, 0);
        drive(0, 1'b1, 8'h10, 4'd3, 32'hA0, 1);
        idle(2);
        push_burst(1, 1'b0, 8'h10, 4'd3, 32'hA0, 0);
        drive(1, 1'b0, 8'h10, 4'd3, 32'h0, 1);
        idle(3);

        // Contention from reset; requester 0 re-requests during its last beat.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk(ram_addr == 8'h00, "reset_addr_after_use", {24'b0, ram_addr}, 32'h0);
        push_burst(0, 1'b1, 8'h20, 4'd1, 32'hB0, 0);
`ifdef RAM_ARB_FIXED_PRIO_EN
        push_burst(0, 1'b1, 8'h40, 4'd0, 32'hD0, 2);
        push_burst(1, 1'b1, 8'h30, 4'd0, 32'hC0, 2);
`else
        push_burst(1, 1'b1, 8'h30, 4'd0, 32'hC0, 2);
        push_burst(0, 1'b1, 8'h40, 4'd0, 32'hD0, 2);
`endif
        fork
            begin
                drive(0, 1'b1, 8'h20, 4'd1, 32'hB0, 1);
                drive(0, 1'b1, 8'h40, 4'd0, 32'hD0, 0);
            end
            drive(1, 1'b1, 8'h30, 4'd0, 32'hC0, 0);
        join
        idle(3);

        // Address wrap 0xFE -> 0x00, then read back.
        push_burst(0, 1'b1, 8'hFE, 4'd2, 32'hE0, 0);
        drive(0, 1'b1, 8'hFE, 4'd2, 32'hE0, 1);
        idle(2);
        push_burst(1, 1'b0, 8'hFE, 4'd2, 32'hE0, 0);
        drive(1, 1'b0, 8'hFE, 4'd2, 32'h0, 1);
        idle(3);

        // Reset during beat 2 of an 8-beat read: only beats 0..2 and rvalids 0..1 appear.
        push_burst(1, 1'b0, 8'h10, 4'd2, 32'hA0, 0);
        void'(rq.pop_back());
        we1 = 1'b0; addr1 = 8'h10; len1 = 4'd7; req1 = 1'b1;
        wait_gnt(1, 1);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk({busy, ram_rw, beat1, beat0, rvalid1, rvalid0} == 6'b0, "abort_state",
            {26'b0, busy, ram_rw, beat1, beat0, rvalid1, rvalid0}, 32'h0);
        idle(3);
        push_burst(0, 1'b0, 8'h30, 4'd0, 32'hC0, 0);
        drive(0, 1'b0, 8'h30, 4'd0, 32'h0, 1);
        idle(3);

        // Requester 1 arrives mid-burst: granted two cycles after the last beat.
        push_burst(0, 1'b0, 8'h20, 4'd1, 32'hB0, 0);
        push_burst(1, 1'b0, 8'hFE, 4'd0, 32'hE0, 2);
        fork
            drive(0, 1'b0, 8'h20, 4'd1, 32'h0, 1);
            begin
                idle(1);
                drive(1, 1'b0, 8'hFE, 4'd0, 32'h0, 3);
            end
        join
        idle(4);

        chk(bq.size() == 0, "beats_outstanding", 32'(bq.size()), 32'h0);
        chk(rq.size() == 0, "reads_outstanding", 32'(rq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-port arbiter and burst sequencer in front of the single-port `Ram256x32`: 256 words, 32 bits each, one access per clock. Two requesters, for example a DMA engine and the CPU, each issue read or write bursts of 1–16 words. The block selects one requester by round-robin, drives the RAM address, data and RW lines beat by beat, and returns read data tagged per requester. It sits between the requester fabric and the RAM's `addr/Din/Dout/RW` pins.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM address width (256 words).
- `DATA_W`, default 32: word width.
- `LEN_W`, default 4: burst length field width. Burst length = `len`+1, so 1–16 beats.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `req0`/`req1`  in  1  burst request. Held until the matching `gnt`.
- `we0`/`we1`  in  1  1 = write burst, 0 = read burst. Must be stable while `req` is high.
- `addr0`/`addr1`  in  ADDR_W  burst start address. Stable while `req` is high.
- `len0`/`len1`  in  LEN_W  beats − 1. Stable while `req` is high.
- `wdata0`/`wdata1`  in  DATA_W  write data for the current beat. Sampled in cycles where `beat` is high.
- `gnt0`/`gnt1`  out  1  one-cycle pulse, asserted in the first beat cycle of the granted burst.
- `beat0`/`beat1`  out  1  high in every cycle the RAM is accessed on that requester's behalf.
- `rvalid0`/`rvalid1`  out  1  read data valid for that requester.
- `rdata0`/`rdata1`  out  DATA_W  read data. Both carry `ram_dout`; qualify with `rvalid`.
- `busy`  out  1  high while a burst is in progress (state BURST).
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_din`  out  DATA_W  to RAM `Din`.
- `ram_rw`  out  1  to RAM `RW`: 1 = write, 0 = read.
- `ram_dout`  in  DATA_W  from RAM `Dout`. Valid one cycle after the read address is presented.

## Operation
- FSM states: IDLE and BURST.
- IDLE:
  - If any `req` is high at an edge, latch the winner's `we`/`addr`/`len`, load the beat counter with `len`, and enter BURST.
  - No requests: remain in IDLE.
- Arbitration: round-robin pointer `prio`, reset to 0.
  - One request high: that requester wins.
  - Both high: requester `prio` wins, and `prio` ← the loser.
  - Single grant: `prio` ← the non-granted requester.
- BURST (one beat per cycle, no stalls):
  - `ram_addr` = latched address + beat index, modulo 256. Wrap 255→0 is legal.
  - `ram_rw` = latched `we`.
  - `ram_din` = winner's `wdata` (combinational mux).
  - `beat` of the winner is high.
  - After the beat with counter = 0, return to IDLE.
- Outputs in IDLE: `ram_rw` = 0 (a harmless read), `ram_addr` holds its last value, `ram_din` = 0, all `beat`/`gnt` = 0.
- Read bursts: `rvalid` of the owner is `beat` delayed one cycle, with `we` = 0 registered alongside it.
- Write bursts: `rvalid` never asserts.
- Requests are arbitrated only in IDLE. A `req` rising during BURST waits.
- The owner must drop `req` after `gnt`. If `req` is still high in IDLE, it is treated as a new burst.

## Timing
- Request seen at edge N (state IDLE). BURST starts at N+1. `gnt` and the first `beat` are high during cycle N+1.
- The burst occupies cycles N+1 … N+1+`len`. IDLE resumes in cycle N+2+`len`, so there is one bubble cycle between bursts.
- Read latency: beat k at cycle t gives `rvalid` and data at cycle t+1. The last `rvalid` lands in the first IDLE cycle.
- Reset values: state = IDLE, `prio` = 0, `ram_addr` = 0, `ram_rw` = 0, `ram_din` = 0. All `gnt`/`beat`/`rvalid`/`busy` = 0.
- Reset mid-burst: the burst is aborted. `ram_rw` = 0 from the next cycle, and a pending `rvalid` is dropped. The requester must re-issue.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins contention and `prio` is removed. Requester 1 is served only when `req0` is low in IDLE.
  - Undefined: round-robin as described above.

## Structure
- Package `ram_arb_pkg` holds:
  - state enum `ram_arb_state_e` {IDLE, BURST};
  - constants `RAM_ADDR_W`=8, `RAM_DATA_W`=32, `RAM_LEN_W`=4.
- Sub-module `ram_arb_rr`: 2-way picker. Inputs are `req[1:0]` and `prio`; outputs are a one-hot `win[1:0]` and the next `prio`. The macro is honoured inside this sub-module.
- The top level holds the FSM, beat counter, address incrementer, read-valid pipeline and RAM muxes.

## Test plan
- After reset, `req0` write, addr 0x10, len 3, wdata 0xA0..0xA3:
  - `gnt0` one cycle later;
  - `ram_rw`=1 on addr 0x10..0x13 over 4 consecutive cycles;
  - `busy` low afterwards.
- `req1` read, addr 0x10, len 3: `rvalid1` for 4 cycles with 0xA0..0xA3, each one cycle after its beat; `rvalid0` stays 0.
- Both requests high in the same cycle, from reset:
  - requester 0 is served first;
  - requester 1 is served after the bubble;
  - on the next simultaneous request, requester 1 wins.
  - With `RAM_ARB_FIXED_PRIO_EN`, requester 0 wins both times.
- Write burst at addr 0xFE, len 2: addresses 0xFE, 0xFF, 0x00. A read back returns the matching data.
- `rst` asserted during beat 2 of an 8-beat read:
  - next cycle: state IDLE, `ram_rw`=0, no further `beat`/`rvalid`;
  - new requests are arbitrated normally afterwards.
- `req1` raised during a requester-0 burst: `gnt1` appears exactly 2 cycles after the last requester-0 beat (bubble cycle, then the grant).
